// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control bundle between the multicycle controller and the datapath.
interface multicycle_controller_if #(
    parameter int ALU_CTRL_W = 4
);
    logic [6:0]            op;
    logic [2:0]            funct3;
    logic                  funct7b5;
    logic                  zero;
    logic                  mem_ready;
    logic                  pc_write;
    logic                  adr_src;
    logic                  mem_write;
    logic                  ir_write;
    logic                  reg_write;
    logic [1:0]            result_src;
    logic [1:0]            alu_src_a;
    logic [1:0]            alu_src_b;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [2:0]            imm_src;
    logic                  illegal_instr;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_ctrl, imm_src, illegal_instr
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_ctrl, imm_src, illegal_instr
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for the multicycle RISC-V datapath.
// Sequences fetch/decode/execute/memory/writeback and drives ALU opcode, mux selects and strobes.
module multicycle_controller #(
    parameter int ALU_CTRL_W = 4
) (
    input logic                      clk,
    input logic                      reset_n,
    multicycle_controller_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL, LUI
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [ALU_CTRL_W-1:0] A_ADD = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] A_SUB = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] A_AND = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] A_OR  = ALU_CTRL_W'(3);
    localparam logic [ALU_CTRL_W-1:0] A_SLL = ALU_CTRL_W'(4);
    localparam logic [ALU_CTRL_W-1:0] A_SLT = ALU_CTRL_W'(5);
    localparam logic [ALU_CTRL_W-1:0] A_XOR = ALU_CTRL_W'(6);
    localparam logic [ALU_CTRL_W-1:0] A_SRL = ALU_CTRL_W'(7);
    localparam logic [ALU_CTRL_W-1:0] A_SRA = ALU_CTRL_W'(8);

    state_t                state_q, state_d;
    logic                  nowb_q, nowb_d;
    logic                  fn_bad;
    logic [ALU_CTRL_W-1:0] fn_alu;
    logic                  pc_write_c, ir_write_c, reg_write_c, mem_write_c, illegal_c;
    logic                  adr_src_c;
    logic [1:0]            result_src_c, src_a_c, src_b_c;
    logic [ALU_CTRL_W-1:0] alu_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            nowb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nowb_q  <= nowb_d;
        end
    end

    always_comb begin
        fn_bad = bus.funct3 == 3'b011;
        case (bus.funct3)
            3'b000:  fn_alu = (bus.op == OP_R && bus.funct7b5) ? A_SUB : A_ADD;
            3'b001:  fn_alu = A_SLL;
            3'b010:  fn_alu = A_SLT;
            3'b100:  fn_alu = A_XOR;
            3'b101:  fn_alu = bus.funct7b5 ? A_SRA : A_SRL;
            3'b110:  fn_alu = A_OR;
            3'b111:  fn_alu = A_AND;
            default: fn_alu = A_ADD;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_STORE: bus.imm_src = 3'b001;
            OP_BR:    bus.imm_src = 3'b010;
            OP_JAL:   bus.imm_src = 3'b011;
            OP_LUI:   bus.imm_src = 3'b100;
            default:  bus.imm_src = 3'b000;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        nowb_d       = 1'b0;
        pc_write_c   = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        mem_write_c  = 1'b0;
        illegal_c    = 1'b0;
        adr_src_c    = 1'b0;
        result_src_c = 2'b00;
        src_a_c      = 2'b00;
        src_b_c      = 2'b00;
        alu_c        = A_ADD;
        case (state_q)
            FETCH: begin
                src_b_c      = 2'b10;
                result_src_c = 2'b10;
                pc_write_c   = bus.mem_ready;
                ir_write_c   = bus.mem_ready;
                state_d      = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // ALU computes old PC + imm here so the branch/jump target is ready in ALUOut
                src_a_c = 2'b01;
                src_b_c = 2'b01;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_R:              state_d = EXECR;
                    OP_I:              state_d = EXECI;
                    OP_BR:             state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_LUI:            state_d = LUI;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                src_a_c = 2'b10;
                src_b_c = 2'b01;
                state_d = bus.op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src_c = 1'b1;
                state_d   = bus.mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                state_d      = FETCH;
            end
            MEMWRITE: begin
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
                state_d     = bus.mem_ready ? FETCH : MEMWRITE;
            end
            EXECR, EXECI: begin
                src_a_c   = 2'b10;
                src_b_c   = (state_q == EXECI) ? 2'b01 : 2'b00;
                alu_c     = fn_alu;
                illegal_c = fn_bad;
                nowb_d    = fn_bad;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write_c = !nowb_q;
                state_d     = FETCH;
            end
            BRANCH: begin
                src_a_c = 2'b10;
                alu_c   = A_SUB;
                if (bus.funct3[2:1] == 2'b00) pc_write_c = bus.zero ^ bus.funct3[0];
                else illegal_c = 1'b1;
                state_d = FETCH;
            end
            JAL: begin
                src_a_c    = 2'b01;
                src_b_c    = 2'b10;
                pc_write_c = 1'b1;
                state_d    = ALUWB;
            end
            LUI: begin
                src_a_c = 2'b11;
                src_b_c = 2'b01;
                state_d = ALUWB;
            end
            default: state_d = FETCH;
        endcase
    end

    // Strobes are gated by reset_n so they drop the instant reset is asserted.
    assign bus.pc_write      = reset_n & pc_write_c;
    assign bus.ir_write      = reset_n & ir_write_c;
    assign bus.reg_write     = reset_n & reg_write_c;
    assign bus.mem_write     = reset_n & mem_write_c;
    assign bus.illegal_instr = reset_n & illegal_c;
    assign bus.adr_src       = adr_src_c;
    assign bus.result_src    = result_src_c;
    assign bus.alu_src_a     = src_a_c;
    assign bus.alu_src_b     = src_b_c;
    assign bus.alu_ctrl      = alu_c;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed and random instruction streams checked against a per-instruction cycle model.
module tb_multicycle_controller;
    typedef struct packed {
        logic       pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sb;
        logic [3:0] alu;
        logic [2:0] imm;
    } obs_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    obs_t eq[$];
    obs_t kq[$];
    bit   mq[$];

    multicycle_controller_if #(.ALU_CTRL_W(4)) bus();
    multicycle_controller #(.ALU_CTRL_W(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic obs_t observe();
        return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
                bus.illegal_instr, bus.result_src, bus.alu_src_a, bus.alu_src_b,
                bus.alu_ctrl, bus.imm_src};
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        if (o == OP_STORE) return 3'b001;
        if (o == OP_BR)    return 3'b010;
        if (o == OP_JAL)   return 3'b011;
        if (o == OP_LUI)   return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f7, input logic r);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd4, 4'd5, 4'd0, 4'd6, 4'd7, 4'd3, 4'd2};
        if (f3 == 3'b000 && r && f7) return 4'd1;
        if (f3 == 3'b101 && f7) return 4'd8;
        return tbl[f3];
    endfunction

    task automatic check(input obs_t e, input obs_t k, input string tag);
        obs_t o;
        o = observe();
        n_vec++;
        assert ((o & k) === (e & k)) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, o & k, e & k);
        end
    endtask

    task automatic push(input obs_t e, input bit mr, input bit alu_dc);
        obs_t k;
        k = '1;
        if (alu_dc) k.alu = 4'h0;
        eq.push_back(e);
        kq.push_back(k);
        mq.push_back(mr);
    endtask

    // Expected output per cycle for one instruction, with fw fetch waits and mw memory waits.
    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                         input int fw, input int mw);
        obs_t b, e;
        eq.delete(); kq.delete(); mq.delete();
        b = '0;
        b.imm = imm_of(o);
        e = b; e.sb = 2'b10; e.rs = 2'b10;
        repeat (fw) push(e, 1'b0, 1'b0);
        e.pcw = 1'b1; e.irw = 1'b1;
        push(e, 1'b1, 1'b0);
        e = b; e.sa = 2'b01; e.sb = 2'b01;
        case (o)
            OP_LOAD, OP_STORE: begin
                push(e, 1'b1, 1'b0);
                e = b; e.sa = 2'b10; e.sb = 2'b01;
                push(e, 1'b1, 1'b0);
                e = b; e.adr = 1'b1; e.mw = o[5];
                repeat (mw) push(e, 1'b0, 1'b0);
                push(e, 1'b1, 1'b0);
                if (!o[5]) begin
                    e = b; e.rs = 2'b01; e.rw = 1'b1;
                    push(e, 1'b1, 1'b0);
                end
            end
            OP_R, OP_I: begin
                push(e, 1'b1, 1'b0);
                e = b; e.sa = 2'b10; e.sb = o[5] ? 2'b00 : 2'b01;
                e.alu = alu_of(f3, f7, o[5]);
                e.ill = f3 == 3'b011;
                push(e, 1'b1, e.ill);
                e = b; e.rw = f3 != 3'b011;
                push(e, 1'b1, 1'b0);
            end
            OP_BR: begin
                push(e, 1'b1, 1'b0);
                e = b; e.sa = 2'b10; e.alu = 4'd1;
                e.ill = f3 > 3'd1;
                e.pcw = !e.ill && (z ^ f3[0]);
                push(e, 1'b1, 1'b0);
            end
            OP_JAL: begin
                push(e, 1'b1, 1'b0);
                e = b; e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1;
                push(e, 1'b1, 1'b0);
                e = b; e.rw = 1'b1;
                push(e, 1'b1, 1'b0);
            end
            OP_LUI: begin
                push(e, 1'b1, 1'b0);
                e = b; e.sa = 2'b11; e.sb = 2'b01;
                push(e, 1'b1, 1'b0);
                e = b; e.rw = 1'b1;
                push(e, 1'b1, 1'b0);
            end
            default: begin
                e.ill = 1'b1;
                push(e, 1'b1, 1'b0);
            end
        endcase
    endtask

    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                       input int fw, input int mw, input string tag, input int nsteps);
        build(o, f3, f7, z, fw, mw);
        bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
        for (int i = 0; i < eq.size() && (nsteps == 0 || i < nsteps); i++) begin
            bus.mem_ready = mq[i];
            @(negedge clk);
            check(eq[i], kq[i], $sformatf("%s[%0d]", tag, i));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        obs_t e;
        logic [6:0] ops [9];
        logic [6:0] o;
        ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_LUI, 7'b0000000, 7'b1100111};
        bus.op = 7'b0; bus.funct3 = 3'b0; bus.funct7b5 = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        e = '0; e.sb = 2'b10; e.rs = 2'b10;
        repeat (3) begin
            @(negedge clk);
            check(e, '1, "reset_hold");
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        run(OP_R, 3'b000, 1'b1, 1'b0, 0, 0, "sub", 0);
        run(OP_LOAD, 3'b010, 1'b0, 1'b0, 0, 2, "load_wait", 0);
        run(OP_BR, 3'b000, 1'b0, 1'b1, 0, 0, "beq", 0);
        run(OP_BR, 3'b001, 1'b0, 1'b1, 0, 0, "bne", 0);
        run(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0, "illegal_op", 0);
        run(OP_R, 3'b011, 1'b0, 1'b0, 0, 0, "sltu", 0);
        run(OP_I, 3'b101, 1'b1, 1'b0, 2, 0, "srai_fwait", 0);
        run(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0, "jal", 0);
        run(OP_LUI, 3'b000, 1'b0, 1'b0, 0, 0, "lui", 0);
        run(OP_STORE, 3'b010, 1'b0, 1'b0, 0, 1, "store", 0);
        run(OP_BR, 3'b100, 1'b0, 1'b0, 0, 0, "blt_illegal", 0);
        run(OP_STORE, 3'b010, 1'b0, 1'b0, 0, 3, "store_rst", 4);
        bus.mem_ready = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        e = '0; e.sb = 2'b10; e.rs = 2'b10; e.imm = 3'b001;
        check(e, '1, "rst_async");
        @(negedge clk);
        check(e, '1, "rst_hold");
        @(posedge clk);
        #1 reset_n = 1'b1;
        run(OP_I, 3'b000, 1'b0, 1'b0, 0, 0, "post_rst", 0);
        for (int n = 0; n < 150; n++) begin
            o = ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            run(o, 3'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2), "rand", 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
